// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
package lsu_pkg;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WSETUP,
        WPULSE,
        RESP
    } lsu_state_e;

    // The unused size encoding 2'b11 behaves as a full word.
    function automatic size_e decode_size(input logic [1:0] raw);
        case (raw)
            2'b00:   return BYTE;
            2'b01:   return HALF;
            default: return WORD;
        endcase
    endfunction

    // Halves must sit on even bytes and words on multiples of four.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] lane);
        return ((size == HALF) && lane[0]) || ((size == WORD) && (lane != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane handling for the load/store controller: extracts and extends load
// data from a memory word, and merges sub-word store data into an old word.
module lsu_align
    import lsu_pkg::*;
(
    input  size_e             size,
    input  logic              zero_ext,
    input  logic [1:0]        lane,
    input  logic [WORD_W-1:0] old_word,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merge_word
);

    logic [BYTE_W-1:0] byte_v;
    logic [HALF_W-1:0] half_v;

    // Select the addressed lane, extend it, and build the merged store word.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves a value unassigned and infers a latch.
        byte_v     = old_word[lane*BYTE_W +: BYTE_W];
        half_v     = lane[1] ? old_word[WORD_W-1:HALF_W] : old_word[HALF_W-1:0];
        load_data  = old_word;
        merge_word = old_word;
        unique case (size)
            BYTE: begin
                load_data = {{(WORD_W-BYTE_W){~zero_ext & byte_v[BYTE_W-1]}}, byte_v};
                merge_word[lane*BYTE_W +: BYTE_W] = wdata[BYTE_W-1:0];
            end
            HALF: begin
                load_data = {{(WORD_W-HALF_W){~zero_ext & half_v[HALF_W-1]}}, half_v};
                if (lane[1]) begin
                    merge_word[WORD_W-1:HALF_W] = wdata[HALF_W-1:0];
                end else begin
                    merge_word[HALF_W-1:0] = wdata[HALF_W-1:0];
                end
            end
            default: begin
                load_data  = old_word;
                merge_word = wdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between the execute stage and a word-addressed data
// memory with a single read/write strobe. Sub-word stores use read-modify-write.
// Optional feature: define LSU_MISALIGN_EXC_EN to answer misaligned half/word
// accesses with rsp_err instead of touching memory; otherwise the low address
// bits below the access size are ignored and rsp_err is tied low.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    size_e       size_q, size_d;
    logic        zext_q, zext_d;
    logic [1:0]  lane_q, lane_d;
    logic [31:0] wdata_q, wdata_d;
    logic        mem_rw_q, mem_rw_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
`ifdef LSU_MISALIGN_EXC_EN
    logic        rsp_err_q, rsp_err_d;
`endif

    logic [31:0] req_idx;
    logic        misalign;
    logic [31:0] load_data;
    logic [31:0] merge_word;
    logic        unused_addr_bits;

    // Upper address bits fall away, so indices wrap modulo DEPTH_WORDS.
    assign unused_addr_bits = ^req_addr;

    lsu_align u_align (
        .size       (size_q),
        .zero_ext   (zext_q),
        .lane       (lane_q),
        .old_word   (mem_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_word (merge_word)
    );

    // Word index of the incoming request, zero-extended to the bus width.
    always_comb begin
        req_idx = '0;
        req_idx[IDX_W-1:0] = req_addr[IDX_W+1:2];
    end

    // Next-state and next-output logic of the access sequencer.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        zext_d      = zext_q;
        lane_d      = lane_q;
        wdata_d     = wdata_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef LSU_MISALIGN_EXC_EN
        rsp_err_d   = rsp_err_q;
        misalign    = is_misaligned(decode_size(req_size), req_addr[1:0]);
`else
        misalign    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d       = req_we;
                    size_d     = decode_size(req_size);
                    zext_d     = req_unsigned;
                    lane_d     = req_addr[1:0];
                    wdata_d    = req_wdata;
                    mem_addr_d = req_idx;
                    if (misalign) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = '0;
`ifdef LSU_MISALIGN_EXC_EN
                        rsp_err_d   = 1'b1;
`endif
                    end else if (req_we && (decode_size(req_size) == WORD)) begin
                        mem_wdata_d = req_wdata;
                        state_d     = WSETUP;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                if (we_q) begin
                    mem_wdata_d = merge_word;
                    state_d     = WSETUP;
                end else begin
                    rsp_rdata_d = load_data;
                    rsp_valid_d = 1'b1;
`ifdef LSU_MISALIGN_EXC_EN
                    rsp_err_d   = 1'b0;
`endif
                    state_d     = RESP;
                end
            end
            WSETUP: begin
                mem_rw_d = 1'b1;
                state_d  = WPULSE;
            end
            WPULSE: begin
                mem_rw_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
`ifdef LSU_MISALIGN_EXC_EN
                rsp_err_d   = 1'b0;
`endif
                state_d     = RESP;
            end
            RESP: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // the values from before this edge; blocking belongs in always_comb.
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= BYTE;
            zext_q      <= 1'b0;
            lane_q      <= 2'b00;
            wdata_q     <= '0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_EXC_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            zext_q      <= zext_d;
            lane_q      <= lane_d;
            wdata_q     <= wdata_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef LSU_MISALIGN_EXC_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign req_ready = (state_q == IDLE);
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef LSU_MISALIGN_EXC_EN
    assign rsp_err   = rsp_err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule
